// File: rtl/queue_pkg.sv
// Shared widths and types for the byte queue that sits behind the deserializer.
package queue_pkg;
  localparam int QUEUE_DATA_W = 8;
  localparam int QUEUE_DEPTH  = 8;

  typedef logic [QUEUE_DATA_W-1:0]        byte_t;
  typedef logic [$clog2(QUEUE_DEPTH)-1:0] qptr_t;
endpackage

// File: rtl/rise_detect.sv
// Turns a level request into a single-cycle pulse on its rising edge.
module rise_detect (
  input  logic clock_1MHz,
  input  logic rst,
  input  logic sig_in,
  output logic pulse_out
);
  logic sig_q;

  always_ff @(posedge clock_1MHz or posedge rst) begin
    if (rst) sig_q <= 1'b0;
    else     sig_q <= sig_in;
  end

  // Combinational so the event is consumed on the very edge that sees the rise.
  assign pulse_out = sig_in & ~sig_q;
endmodule

// File: rtl/byte_queue.sv
// Circular byte FIFO fed by the deserializer; exposes occupancy and full/empty flags.
module byte_queue
  import queue_pkg::*;
#(
  parameter int DATA_W = QUEUE_DATA_W,
  parameter int DEPTH  = QUEUE_DEPTH,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clock_1MHz,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              enqueue_in,
  input  logic              dequeue_in,
  output logic [DATA_W-1:0] data_out,
  output logic              deq_valid_out,
  output logic [CNT_W-1:0]  len_out,
  output logic              full_out,
  output logic              empty_out,
  output logic              error_out
);
  localparam int PTR_W = $clog2(DEPTH);

  // Request semantics: each rising edge of enqueue_in/dequeue_in is one request.
  // A request is either accepted (enqueue stores data_in, dequeue updates data_out
  // with a deq_valid_out pulse) or rejected with a one-cycle error_out pulse.
  // There is no back-pressure; the requester watches full_out/empty_out.
  logic enq_ev, deq_ev;
  logic enq_ok, deq_ok;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  len;

  rise_detect u_enq_rise (
    .clock_1MHz (clock_1MHz),
    .rst        (rst),
    .sig_in     (enqueue_in),
    .pulse_out  (enq_ev)
  );

  rise_detect u_deq_rise (
    .clock_1MHz (clock_1MHz),
    .rst        (rst),
    .sig_in     (dequeue_in),
    .pulse_out  (deq_ev)
  );

  assign full_out  = (len == CNT_W'(DEPTH));
  assign empty_out = (len == '0);
  assign len_out   = len;

  // A full queue still takes a byte when a dequeue frees a slot on the same edge;
  // an empty queue never bypasses the incoming byte to data_out.
  assign deq_ok = deq_ev & ~empty_out;
  assign enq_ok = enq_ev & (~full_out | deq_ok);

  always_ff @(posedge clock_1MHz) begin
    if (enq_ok) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clock_1MHz or posedge rst) begin
    if (rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      len           <= '0;
      data_out      <= '0;
      deq_valid_out <= 1'b0;
      error_out     <= 1'b0;
    end else begin
      deq_valid_out <= deq_ok;
      error_out     <= (enq_ev & ~enq_ok) | (deq_ev & ~deq_ok);
      if (enq_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (deq_ok) begin
        rd_ptr   <= rd_ptr + PTR_W'(1);
        data_out <= mem[rd_ptr];
      end
      case ({enq_ok, deq_ok})
        2'b10:   len <= len + CNT_W'(1);
        2'b01:   len <= len - CNT_W'(1);
        default: len <= len;
      endcase
    end
  end
endmodule
